// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared state encoding and port ids for ram_arbiter
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/ram_arbiter_pick.sv
// rtl/ram_arbiter_pick.sv - 2-way winner select, round robin under RAM_ARBITER_ROUND_ROBIN_EN
module ram_arbiter_pick
    import ram_arbiter_pkg::*;
(
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    input  logic last,
`endif
    input  logic a_req,
    input  logic b_req,
    output logic valid,
    output logic id
);

    // Single requester always wins; a tie goes to A unless A was served last
    always_comb begin
        valid = a_req | b_req;
        id    = PORT_A;
        if (a_req && b_req) begin
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
            id = (last == PORT_A) ? PORT_B : PORT_A;
`else
            id = PORT_A;
`endif
        end else if (b_req) begin
            id = PORT_B;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port req/ack arbiter for a single-port RAM (option: RAM_ARBITER_ROUND_ROBIN_EN)
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_cs_n,
    output logic              ram_we_n,
    output logic              ram_oe_n
);

    state_t state, next_state;
    logic   id_q;
    logic   we_q;
    logic   pick_valid;
    logic   pick_id;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    logic last_q;
`endif

    ram_arbiter_pick u_pick (
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
        .last  (last_q),
`endif
        .a_req (a_req),
        .b_req (b_req),
        .valid (pick_valid),
        .id    (pick_id)
    );

    // Route the winning port's command toward the RAM-facing registers
    always_comb begin
        win_we    = a_we;
        win_addr  = a_addr;
        win_wdata = a_wdata;
        if (pick_id == PORT_B) begin
            win_we    = b_we;
            win_addr  = b_addr;
            win_wdata = b_wdata;
        end
    end

    // State register; reset forces IDLE so strobes and acks drop at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Command capture in IDLE, read-data capture at the edge ending SERVE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_q      <= PORT_A;
            we_q      <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            if (state == IDLE && pick_valid) begin
                id_q      <= pick_id;
                we_q      <= win_we;
                ram_addr  <= win_addr;
                ram_wdata <= win_wdata;
            end
            if (state == SERVE && !we_q) begin
                if (id_q == PORT_A) begin
                    a_rdata <= ram_rdata;
                end else begin
                    b_rdata <= ram_rdata;
                end
            end
        end
    end

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    // Remember who finished last so the next tie goes the other way
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= PORT_B;
        end else if (state == ACK) begin
            last_q <= id_q;
        end
    end
`endif

    // Next state, RAM strobes and ack pulses
    always_comb begin
        next_state = state;
        ram_cs_n   = 1'b1;
        ram_we_n   = 1'b1;
        ram_oe_n   = 1'b1;
        a_ack      = 1'b0;
        b_ack      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    next_state = SERVE;
                end
            end
            SERVE: begin
                ram_cs_n   = 1'b0;
                ram_we_n   = ~we_q;
                ram_oe_n   = we_q;
                next_state = ACK;
            end
            ACK: begin
                a_ack      = (id_q == PORT_A);
                b_ack      = (id_q == PORT_B);
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter
module tb_ram_arbiter;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       a_req, a_we, a_ack;
    logic [5:0] a_addr;
    logic [7:0] a_wdata, a_rdata;
    logic       b_req, b_we, b_ack;
    logic [5:0] b_addr;
    logic [7:0] b_wdata, b_rdata;
    logic [5:0] ram_addr;
    logic [7:0] ram_wdata, ram_rdata;
    logic       ram_cs_n, ram_we_n, ram_oe_n;

    logic [7:0] mem [0:63];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr];

    always @(posedge clk) begin
        if (!ram_cs_n && !ram_we_n) mem[ram_addr] <= ram_wdata;
    end

    ram_arbiter #(.ADDR_W(6), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_ack     (a_ack),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_ack     (b_ack),
        .b_rdata   (b_rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_cs_n  (ram_cs_n),
        .ram_we_n  (ram_we_n),
        .ram_oe_n  (ram_oe_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic single(input logic port, input logic we, input logic [5:0] addr,
                          input logic [7:0] wd, input string tag);
        int n;
        bit got;
        n   = 0;
        got = 0;
        @(negedge clk);
        if (port) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
        end
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (port ? b_ack : a_ack) got = 1;
        end
        check({tag, "_latency"}, n, 2);
        check({tag, "_other_ack"}, port ? a_ack : b_ack, 1'b0);
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    task automatic tie(input string tag, input logic [31:0] exp_first);
        int cyc, first, ta, tb;
        cyc = 0; first = -1; ta = 0; tb = 0;
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 6'h05;
        b_req = 1'b1; b_we = 1'b0; b_addr = 6'h3F;
        while ((a_req || b_req) && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (a_ack) begin
                if (first < 0) first = 0;
                ta = cyc;
                a_req = 1'b0;
            end
            if (b_ack) begin
                if (first < 0) first = 1;
                tb = cyc;
                b_req = 1'b0;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        check({tag, "_first"}, first, exp_first);
        check({tag, "_a_cycle"}, ta, exp_first == 0 ? 2 : 5);
        check({tag, "_b_cycle"}, tb, exp_first == 1 ? 2 : 5);
        check({tag, "_a_rdata"}, a_rdata, 8'h3C);
        check({tag, "_b_rdata"}, b_rdata, 8'hFF);
    endtask

    initial begin
        int a_cnt, b_cnt, cyc;

        rst = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", ram_cs_n, 1'b1);
        check("rst_we_n", ram_we_n, 1'b1);
        check("rst_oe_n", ram_oe_n, 1'b1);
        check("rst_acks", {a_ack, b_ack}, 2'b00);
        check("rst_rdata", {a_rdata, b_rdata}, 16'h0000);
        check("rst_addr", ram_addr, 6'h00);
        rst = 1'b1;

        // A writes 0x3C to 0x05, checked cycle by cycle
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = 6'h05; a_wdata = 8'h3C;
        @(negedge clk);
        check("wr_serve_cs_n", ram_cs_n, 1'b0);
        check("wr_serve_we_n", ram_we_n, 1'b0);
        check("wr_serve_oe_n", ram_oe_n, 1'b1);
        check("wr_serve_addr", ram_addr, 6'h05);
        check("wr_serve_wdata", ram_wdata, 8'h3C);
        check("wr_serve_ack", a_ack, 1'b0);
        @(negedge clk);
        check("wr_ack_cs_n", ram_cs_n, 1'b1);
        check("wr_ack_we_n", ram_we_n, 1'b1);
        check("wr_ack_a", a_ack, 1'b1);
        check("wr_ack_b", b_ack, 1'b0);
        a_req = 1'b0;
        @(negedge clk);
        check("wr_after_ack", a_ack, 1'b0);
        check("wr_rdata_kept", a_rdata, 8'h00);

        single(1'b0, 1'b0, 6'h05, 8'h00, "a_rd05");
        check("a_rd05_data", a_rdata, 8'h3C);
        check("a_rd05_b_rdata", b_rdata, 8'h00);

        single(1'b1, 1'b1, 6'h3F, 8'hFF, "b_wr3f");
        check("b_wr3f_b_rdata", b_rdata, 8'h00);

        tie("tie1", 0);

        single(1'b0, 1'b0, 6'h3F, 8'h00, "a_rd3f");
        check("a_rd3f_data", a_rdata, 8'hFF);

        tie("tie2", RR ? 1 : 0);

        // A requests continuously for 10 accesses while B waits
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 6'h05;
        b_req = 1'b1; b_we = 1'b0; b_addr = 6'h3F;
        a_cnt = 0; b_cnt = 0; cyc = 0;
        while (a_cnt < 10 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (a_ack) begin
                a_cnt++;
                a_addr = (a_addr == 6'h05) ? 6'h3F : 6'h05;
            end
            if (b_ack) begin
                b_cnt++;
                b_req = 1'b0;
            end
        end
        a_req = 1'b0;
        check("stream_a_count", a_cnt, 10);
        check("stream_b_during", b_cnt, RR ? 1 : 0);
        check("stream_a_rdata", a_rdata, 8'hFF);
        cyc = 0;
        while (b_req && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (b_ack) begin
                b_cnt++;
                b_req = 1'b0;
            end
        end
        b_req = 1'b0;
        check("stream_b_total", b_cnt, 1);
        check("stream_b_rdata", b_rdata, 8'hFF);

        // Reset pulsed during SERVE of an A write
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = 6'h10; a_wdata = 8'h55;
        @(posedge clk);
        #2;
        check("rs_serve_cs_n", ram_cs_n, 1'b0);
        rst = 1'b0;
        #1;
        check("rs_strobes", {ram_cs_n, ram_we_n, ram_oe_n}, 3'b111);
        check("rs_addr", ram_addr, 6'h00);
        @(negedge clk);
        a_req = 1'b0;
        check("rs_no_ack0", a_ack, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("rs_no_ack1", a_ack, 1'b0);
        @(negedge clk);
        check("rs_no_ack2", a_ack, 1'b0);
        check("rs_idle_strobes", ram_cs_n, 1'b1);
        single(1'b0, 1'b0, 6'h05, 8'h00, "rs_next");
        check("rs_next_data", a_rdata, 8'h3C);

        // Reset pulsed during ACK drops the ack immediately
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 6'h3F;
        @(negedge clk);
        @(negedge clk);
        check("ra_ack_seen", a_ack, 1'b1);
        rst = 1'b0;
        #1;
        check("ra_ack_drop", a_ack, 1'b0);
        check("ra_rdata_reset", a_rdata, 8'h00);
        a_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
